uart_frame_assembler: RTL and testbench

//  Assembles UART bytes into command frames: 1 opcode byte, then NUM_OPERANDS operands of OPERAND_BYTES bytes each.

---
 rtl/uart_frame_pkg.sv | 17 +
 rtl/uart_frame_assembler_if.sv | 27 ++
 rtl/uart_frame_timer.sv | 36 +++
 rtl/uart_frame_assembler.sv | 122 ++++++++++++
 tb/tb_uart_frame_assembler.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and sizing helpers for the UART frame assembler
package uart_frame_pkg;

  typedef enum logic [1:0] {
    FA_IDLE    = 2'd0,
    FA_COLLECT = 2'd1
  } fa_state_t;

  function automatic int frame_bytes(input int nops, input int opb);
    return 1 + nops * opb;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_frame_assembler_if.sv
// rtl/uart_frame_assembler_if.sv - byte input and frame output bundle of the frame assembler
interface uart_frame_assembler_if #(
  parameter int NUM_OPERANDS  = 2,
  parameter int OPERAND_BYTES = 1
);
  localparam int OPW = 8 * OPERAND_BYTES;

  logic                        rx_valid;
  logic [7:0]                  rx_data;
  logic [7:0]                  opcode;
  logic [NUM_OPERANDS*OPW-1:0] operands;
  logic                        frame_valid;
  logic                        frame_ready;
  logic                        busy;
  logic                        overrun;
  logic                        timeout_err;

  modport master (
    input  rx_valid, rx_data, frame_ready,
    output opcode, operands, frame_valid, busy, overrun, timeout_err
  );

  modport slave (
    output rx_valid, rx_data, frame_ready,
    input  opcode, operands, frame_valid, busy, overrun, timeout_err
  );
endinterface

// File: rtl/uart_frame_timer.sv
// rtl/uart_frame_timer.sv - inter-byte idle counter; pulses expire after TIMEOUT_CYCLES idle cycles
module uart_frame_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign o_expire = 1'b0;
    end else begin : g_on
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

      logic [TW-1:0] r_count;
      logic          w_hit;

      // A clear (new byte) in the expiry cycle wins, so that byte is never lost.
      assign w_hit    = i_run && !i_clear && (r_count == LIMIT);
      assign o_expire = w_hit;

      always_ff @(posedge clk) begin
        if (reset || i_clear || w_hit) begin
          r_count <= '0;
        end else if (i_run && (r_count != '1)) begin
          r_count <= r_count + TW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/uart_frame_assembler.sv
// rtl/uart_frame_assembler.sv - packs UART bytes into opcode+operand frames with valid/ready output
module uart_frame_assembler
  import uart_frame_pkg::*;
#(
  parameter int NUM_OPERANDS   = 2,
  parameter int OPERAND_BYTES  = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_frame_assembler_if.master fa
);

  localparam int OPW         = 8 * OPERAND_BYTES;
  localparam int OPS_W       = NUM_OPERANDS * OPW;
  localparam int FRAME_BYTES = frame_bytes(NUM_OPERANDS, OPERAND_BYTES);
  localparam int IDX_W       = idx_width(FRAME_BYTES);
  localparam int LAST_LANE   = (NUM_OPERANDS - 1) * OPERAND_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  fa_state_t        r_state, w_state_next;
  logic [IDX_W-1:0] r_byte_idx, w_byte_idx_next;
  logic [7:0]       r_shadow_op;
  logic [OPS_W-1:0] r_shadow_opnd, w_frame_opnd;
  logic [7:0]       r_opcode;
  logic [OPS_W-1:0] r_operands;
  logic             r_frame_valid, r_overrun, r_timeout_err;
  logic             w_last, w_out_free, w_load, w_expire, w_timer_clear, w_timer_run;

  assign w_last        = fa.rx_valid && (r_byte_idx == LAST_IDX);
  assign w_out_free    = !r_frame_valid || fa.frame_ready;
  assign w_load        = w_last && w_out_free;
  assign w_timer_clear = fa.rx_valid || (r_state == FA_IDLE);

  always_comb begin
    w_byte_idx_next = r_byte_idx;
    if (w_expire) begin
      w_byte_idx_next = '0;
    end else if (fa.rx_valid) begin
      w_byte_idx_next = w_last ? '0 : r_byte_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FA_IDLE;
      r_byte_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_byte_idx <= w_byte_idx_next;
    end
  end

  always_comb begin
    w_state_next = (w_byte_idx_next != '0) ? FA_COLLECT : FA_IDLE;
  end

  always_comb begin
    fa.busy     = (r_state == FA_COLLECT);
    w_timer_run = (r_state == FA_COLLECT);
  end

  // Operands are big-endian inside, but operand 0 sits at the low end of the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_op   <= '0;
      r_shadow_opnd <= '0;
    end else if (fa.rx_valid) begin
      if (r_byte_idx == '0) begin
        r_shadow_op <= fa.rx_data;
      end
      for (int k = 0; k < NUM_OPERANDS * OPERAND_BYTES; k++) begin
        if (r_byte_idx == IDX_W'(k + 1)) begin
          r_shadow_opnd[((k / OPERAND_BYTES) * OPERAND_BYTES
                         + (OPERAND_BYTES - 1 - (k % OPERAND_BYTES))) * 8 +: 8] <= fa.rx_data;
        end
      end
    end
  end

  always_comb begin
    w_frame_opnd                     = r_shadow_opnd;
    w_frame_opnd[LAST_LANE*8 +: 8]   = fa.rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode      <= '0;
      r_operands    <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_overrun     <= w_last && !w_out_free;
      r_timeout_err <= w_expire;
      if (w_load) begin
        r_opcode      <= r_shadow_op;
        r_operands    <= w_frame_opnd;
        r_frame_valid <= 1'b1;
      end else if (r_frame_valid && fa.frame_ready) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign fa.opcode      = r_opcode;
  assign fa.operands    = r_operands;
  assign fa.frame_valid = r_frame_valid;
  assign fa.overrun     = r_overrun;
  assign fa.timeout_err = r_timeout_err;

  uart_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_timer_clear),
    .i_run   (w_timer_run),
    .o_expire(w_expire)
  );

endmodule

// File: tb/tb_uart_frame_assembler.sv
// tb/tb_uart_frame_assembler.sv - directed bench over three assembler configurations
module tb_uart_frame_assembler;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart_frame_assembler_if #(.NUM_OPERANDS(2), .OPERAND_BYTES(1)) ia ();
  uart_frame_assembler_if #(.NUM_OPERANDS(2), .OPERAND_BYTES(2)) ib ();
  uart_frame_assembler_if #(.NUM_OPERANDS(2), .OPERAND_BYTES(1)) ic ();

  uart_frame_assembler #(.NUM_OPERANDS(2), .OPERAND_BYTES(1), .TIMEOUT_CYCLES(50000)) u_a (
    .clk(clk), .reset(reset), .fa(ia)
  );
  uart_frame_assembler #(.NUM_OPERANDS(2), .OPERAND_BYTES(2), .TIMEOUT_CYCLES(50000)) u_b (
    .clk(clk), .reset(reset), .fa(ib)
  );
  uart_frame_assembler #(.NUM_OPERANDS(2), .OPERAND_BYTES(1), .TIMEOUT_CYCLES(16)) u_c (
    .clk(clk), .reset(reset), .fa(ic)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] b);
    @(negedge clk);
    case (d)
      0: begin ia.rx_valid = 1'b1; ia.rx_data = b; end
      1: begin ib.rx_valid = 1'b1; ib.rx_data = b; end
      default: begin ic.rx_valid = 1'b1; ic.rx_data = b; end
    endcase
    @(negedge clk);
    ia.rx_valid = 1'b0;
    ib.rx_valid = 1'b0;
    ic.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    ia.rx_valid = 1'b0; ia.rx_data = 8'h00; ia.frame_ready = 1'b1;
    ib.rx_valid = 1'b0; ib.rx_data = 8'h00; ib.frame_ready = 1'b1;
    ic.rx_valid = 1'b0; ic.rx_data = 8'h00; ic.frame_ready = 1'b1;
    idle(3);
    check("rst_opcode", ia.opcode, 64'h0);
    check("rst_operands", ia.operands, 64'h0);
    check("rst_valid", ia.frame_valid, 64'h0);
    check("rst_busy", ia.busy, 64'h0);
    check("rst_overrun", ia.overrun, 64'h0);
    check("rst_timeout", ia.timeout_err, 64'h0);
    reset = 1'b0;

    // basic 3-byte frame
    send(0, 8'h01); idle(1);
    send(0, 8'h12);
    check("t1_busy_mid", ia.busy, 64'h1);
    idle(1);
    send(0, 8'h34);
    check("t1_valid", ia.frame_valid, 64'h1);
    check("t1_opcode", ia.opcode, 64'h01);
    check("t1_operands", ia.operands, 64'h3412);
    check("t1_busy_done", ia.busy, 64'h0);
    idle(1);
    check("t1_valid_drop", ia.frame_valid, 64'h0);
    check("t1_opcode_hold", ia.opcode, 64'h01);

    // overrun while output held
    ia.frame_ready = 1'b0;
    send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
    check("t3_valid_a", ia.frame_valid, 64'h1);
    check("t3_operands_a", ia.operands, 64'h0302);
    send(0, 8'h04); send(0, 8'h05);
    check("t3_overrun_early", ia.overrun, 64'h0);
    send(0, 8'h06);
    check("t3_overrun", ia.overrun, 64'h1);
    check("t3_valid_kept", ia.frame_valid, 64'h1);
    check("t3_opcode_kept", ia.opcode, 64'h01);
    check("t3_operands_kept", ia.operands, 64'h0302);
    check("t3_busy", ia.busy, 64'h0);
    idle(1);
    check("t3_overrun_pulse", ia.overrun, 64'h0);
    ia.frame_ready = 1'b1;
    idle(1);
    check("t3_valid_drop", ia.frame_valid, 64'h0);

    // consume and completion on the same edge
    ia.frame_ready = 1'b0;
    send(0, 8'h0A); send(0, 8'h0B); send(0, 8'h0C);
    check("b2b_first", ia.opcode, 64'h0A);
    send(0, 8'h0D); send(0, 8'h0E);
    @(negedge clk);
    ia.frame_ready = 1'b1;
    ia.rx_valid = 1'b1;
    ia.rx_data = 8'h0F;
    @(negedge clk);
    ia.rx_valid = 1'b0;
    check("b2b_valid", ia.frame_valid, 64'h1);
    check("b2b_opcode", ia.opcode, 64'h0D);
    check("b2b_operands", ia.operands, 64'h0F0E);
    check("b2b_overrun", ia.overrun, 64'h0);
    idle(1);
    check("b2b_drop", ia.frame_valid, 64'h0);

    // two-byte operands
    send(1, 8'h07); send(1, 8'hAB); send(1, 8'hCD); send(1, 8'h00); send(1, 8'h10);
    check("t2_valid", ib.frame_valid, 64'h1);
    check("t2_opcode", ib.opcode, 64'h07);
    check("t2_operands", ib.operands, 64'h0010ABCD);

    // timeout discards partial frame
    send(2, 8'h09); send(2, 8'h11);
    idle(15);
    check("t4_no_early_timeout", ic.timeout_err, 64'h0);
    check("t4_busy_wait", ic.busy, 64'h1);
    idle(1);
    check("t4_timeout", ic.timeout_err, 64'h1);
    check("t4_busy_clear", ic.busy, 64'h0);
    idle(1);
    check("t4_timeout_pulse", ic.timeout_err, 64'h0);
    idle(3);
    send(2, 8'h02); send(2, 8'h03); send(2, 8'h04);
    check("t4_valid", ic.frame_valid, 64'h1);
    check("t4_opcode", ic.opcode, 64'h02);
    check("t4_operands", ic.operands, 64'h0403);

    // byte lands in the expiry cycle
    send(2, 8'h21);
    idle(14);
    send(2, 8'h22);
    check("t5_no_timeout", ic.timeout_err, 64'h0);
    check("t5_busy", ic.busy, 64'h1);
    idle(1);
    check("t5_no_timeout_after", ic.timeout_err, 64'h0);
    send(2, 8'h23);
    check("t5_valid", ic.frame_valid, 64'h1);
    check("t5_opcode", ic.opcode, 64'h21);
    check("t5_operands", ic.operands, 64'h2322);

    // reset mid-frame with a pending frame
    ia.frame_ready = 1'b0;
    send(0, 8'h31); send(0, 8'h32); send(0, 8'h33);
    check("t6_pending", ia.frame_valid, 64'h1);
    send(0, 8'h41); send(0, 8'h42);
    check("t6_busy", ia.busy, 64'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_valid_rst", ia.frame_valid, 64'h0);
    check("t6_opcode_rst", ia.opcode, 64'h0);
    check("t6_operands_rst", ia.operands, 64'h0);
    check("t6_busy_rst", ia.busy, 64'h0);
    ia.frame_ready = 1'b1;
    send(0, 8'h51); send(0, 8'h52); send(0, 8'h53);
    check("t6_valid", ia.frame_valid, 64'h1);
    check("t6_opcode", ia.opcode, 64'h51);
    check("t6_operands", ia.operands, 64'h5352);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
